// File: rtl/hazard_tracker.sv
// Scoreboard shadowing the EX/MEM/WB slots of the 5-stage pipeline: forwarding sources, load-use stalls, data waits.
// Define HAZARD_STATS_EN to build the saturating stall_count statistics counter.
module hazard_tracker #(
    parameter int unsigned REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wen,
    input  logic             id_memrd,
    input  logic             id_memwr,
    input  logic             flush,
    output logic [REG_W-1:0] reg_wr_mem,
    output logic [REG_W-1:0] reg_wr_wb,
    output logic             wen_ex_mem,
    output logic             wen_mem_wb,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             freeze,
    output logic [31:0]      stall_count
);

    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wen;
        logic             memrd;
        logic             memwr;
    } slot_t;

    typedef enum logic [1:0] {RUN, LU_STALL, DWAIT} state_t;

    state_t           state;
    slot_t            ex_q;
    slot_t            mem_q;
    slot_t            id_slot;
    logic [REG_W-1:0] wb_dest;
    logic             wb_wen;
    logic             mem_busy;
    logic             advance;
    logic             lu;

    always_comb begin
        id_slot       = '0;
        id_slot.dest  = id_dest;
        // a write to $zero is never a forwarding source
        id_slot.wen   = id_wen & (id_dest != '0);
        id_slot.memrd = id_memrd;
        id_slot.memwr = id_memwr;
    end

    always_comb begin
        mem_busy  = (mem_q.memrd | mem_q.memwr) & ~dhit;
        advance   = ihit & ~mem_busy;
        lu        = ex_q.memrd & ex_q.wen & ((ex_q.dest == id_rs) | (ex_q.dest == id_rt));
        freeze    = mem_busy;
        stall_id  = lu & ~flush;
        bubble_ex = lu | flush;
    end

    assign reg_wr_mem = mem_q.dest;
    assign wen_ex_mem = mem_q.wen;
    assign reg_wr_wb  = wb_dest;
    assign wen_mem_wb = wb_wen;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy)
                        state <= DWAIT;
                    else if (advance & lu & ~flush)
                        state <= LU_STALL;
                end
                LU_STALL: begin
                    if (mem_busy)
                        state <= DWAIT;
                    else if (advance)
                        state <= RUN;
                end
                DWAIT: begin
                    if (dhit)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_dest <= '0;
            wb_wen  <= 1'b0;
        end else if (advance) begin
            wb_dest <= mem_q.dest;
            wb_wen  <= mem_q.wen;
            mem_q   <= ex_q;
            ex_q    <= bubble_ex ? '0 : id_slot;
        end else begin
            // WB retires into a bubble so a held write is presented only once
            wb_dest <= '0;
            wb_wen  <= 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall_q <= '0;
        else if ((stall_id | freeze) && (stall_q != '1))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule
